// File: rtl/pipe_stage_chain.sv
// Pipeline register chain: DEPTH stages of {valid, data} with global enable, synchronous flush
// and a registered occupancy count. Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_chain #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         valid_i,
    input  logic [WIDTH-1:0]             d,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         busy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        occ_d   = occ_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = FLUSH_VAL;
            end
            valid_d = '0;
            occ_d   = '0;
        end else if (en) begin
            data_d[0]  = d;
            valid_d[0] = valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // The word leaving the last stage and the word entering stage 0 cancel when both valid.
            occ_d = occ_q - OCC_W'(valid_q[DEPTH-1]) + OCC_W'(valid_i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= FLUSH_VAL;
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign q         = data_q[DEPTH-1];
    assign valid_o   = valid_q[DEPTH-1];
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    // Flush does not clear the counter; only reset does.
    always_comb begin
        stall_d = stall_q;
        if (!en && !flush && busy && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a vector table on a DEPTH=3 chain plus hand-written
// sequences for reset, bubbles (DEPTH=2, non-zero flush value), DEPTH=1 and the stall counter.
module tb_pipe_stage_chain;

    logic        clock;
    logic        reset_n;
    logic        en;
    logic        flush;
    logic        valid_i;
    logic [31:0] d;

    logic        vo3, vo2, vo1;
    logic [31:0] q3, q1;
    logic [7:0]  q2;
    logic [1:0]  occ3, occ2;
    logic        occ1;
    logic        busy3, busy2, busy1;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] sc3, sc2, sc1;
`endif

    int total  = 0;
    int passed = 0;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .FLUSH_VAL(32'h0)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .en(en), .flush(flush), .valid_i(valid_i), .d(d),
        .valid_o(vo3), .q(q3), .occupancy(occ3), .busy(busy3)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(sc3)
`endif
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(2), .FLUSH_VAL(8'hA5)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .en(en), .flush(flush), .valid_i(valid_i), .d(d[7:0]),
        .valid_o(vo2), .q(q2), .occupancy(occ2), .busy(busy2)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(sc2)
`endif
    );

    pipe_stage_chain #(.WIDTH(32), .DEPTH(1), .FLUSH_VAL(32'h0)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .en(en), .flush(flush), .valid_i(valid_i), .d(d),
        .valid_o(vo1), .q(q1), .occupancy(occ1), .busy(busy1)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(sc1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        fl;
        logic        vi;
        logic [31:0] d;
        logic        evo;
        logic [31:0] eq;
        logic [1:0]  eocc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic f, input logic v, input logic [31:0] dd,
                                input logic evo, input logic [31:0] eq, input logic [1:0] eocc);
        vec_t r;
        r.en = e; r.fl = f; r.vi = v; r.d = dd; r.evo = evo; r.eq = eq; r.eocc = eocc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [31:0] dd);
        en = e; flush = f; valid_i = v; d = dd;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        reset_n = 1'b0;

        // Reset held with active inputs: everything stays cleared.
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_vo3", {31'd0, vo3}, 32'd0);
            chk("rst_q3", q3, 32'd0);
            chk("rst_occ3", {30'd0, occ3}, 32'd0);
            chk("rst_busy3", {31'd0, busy3}, 32'd0);
            chk("rst_q2", {24'd0, q2}, 32'h0000_00A5);
            chk("rst_vo2", {31'd0, vo2}, 32'd0);
        end
        reset_n = 1'b1;

        // en fl vi d | valid_o q occupancy  (DEPTH=3, FLUSH_VAL=0)
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1,  1'b0, 32'h0,  2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h2,  1'b0, 32'h0,  2'd2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h3,  1'b1, 32'h1,  2'd3));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h4,  1'b1, 32'h2,  2'd3));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h5,  1'b1, 32'h3,  2'd3));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  2'd2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h5,  2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'hA,  1'b0, 32'h0,  2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'hB,  1'b0, 32'h0,  2'd2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'hC,  1'b1, 32'hA,  2'd3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h77, 1'b1, 32'hA, 2'd3));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'hB,  2'd2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 32'hC,  2'd2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 32'h0,  2'd2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 32'h11, 2'd3));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 32'h0,  2'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h66, 1'b0, 32'h0,  2'd1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0,  2'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h99, 1'b0, 32'h0,  2'd1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h99, 2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].fl, vecs[i].vi, vecs[i].d);
            tick();
            chk($sformatf("v%0d_valid_o", i), {31'd0, vo3}, {31'd0, vecs[i].evo});
            chk($sformatf("v%0d_q", i), q3, vecs[i].eq);
            chk($sformatf("v%0d_occ", i), {30'd0, occ3}, {30'd0, vecs[i].eocc});
            chk($sformatf("v%0d_busy", i), {31'd0, busy3}, {31'd0, (vecs[i].eocc != 2'd0)});
        end

        // Flush on DEPTH=2 loads its non-zero flush value.
        drive(1'b1, 1'b0, 1'b1, 32'h3C);
        tick();
        tick();
        chk("d2_pre_flush_q", {24'd0, q2}, 32'h3C);
        drive(1'b1, 1'b1, 1'b1, 32'h55);
        tick();
        chk("d2_flush_q", {24'd0, q2}, 32'hA5);
        chk("d2_flush_occ", {30'd0, occ2}, 32'd0);

        // Asynchronous reset mid-operation clears without a clock edge.
        drive(1'b1, 1'b0, 1'b1, 32'h5A);
        tick(); tick(); tick();
        chk("pre_rst_occ3", {30'd0, occ3}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_occ3", {30'd0, occ3}, 32'd0);
        chk("async_rst_vo3", {31'd0, vo3}, 32'd0);
        chk("async_rst_q3", q3, 32'd0);
        chk("async_rst_q2", {24'd0, q2}, 32'hA5);
        chk("async_rst_busy1", {31'd0, busy1}, 32'd0);
        #1 reset_n = 1'b1;

        // Bubbles: DEPTH=2 and DEPTH=1 with valid_i 1,0,1 on d 7,8,9.
        drive(1'b1, 1'b0, 1'b1, 32'd7);
        tick();
        chk("bub_e1_vo2", {31'd0, vo2}, 32'd0);
        chk("bub_e1_q2", {24'd0, q2}, 32'hA5);
        chk("bub_e1_occ2", {30'd0, occ2}, 32'd1);
        chk("bub_e1_q1", q1, 32'd7);
        chk("bub_e1_vo1", {31'd0, vo1}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'd8);
        tick();
        chk("bub_e2_vo2", {31'd0, vo2}, 32'd1);
        chk("bub_e2_q2", {24'd0, q2}, 32'd7);
        chk("bub_e2_occ2", {30'd0, occ2}, 32'd1);
        chk("bub_e2_vo1", {31'd0, vo1}, 32'd0);
        chk("bub_e2_q1", q1, 32'd8);
        drive(1'b1, 1'b0, 1'b1, 32'd9);
        tick();
        chk("bub_e3_vo2", {31'd0, vo2}, 32'd0);
        chk("bub_e3_q2", {24'd0, q2}, 32'd8);
        chk("bub_e3_occ2", {30'd0, occ2}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        chk("bub_e4_vo2", {31'd0, vo2}, 32'd1);
        chk("bub_e4_q2", {24'd0, q2}, 32'd9);
        chk("bub_e4_occ2", {30'd0, occ2}, 32'd1);
        tick();
        chk("bub_e5_vo2", {31'd0, vo2}, 32'd0);
        chk("bub_e5_occ2", {30'd0, occ2}, 32'd0);
        chk("bub_e5_busy2", {31'd0, busy2}, 32'd0);

        // DEPTH=1 stall holds the register.
        drive(1'b1, 1'b0, 1'b1, 32'h1234);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h9999);
        tick(); tick();
        chk("d1_stall_q", q1, 32'h1234);
        chk("d1_stall_occ", {31'd0, occ1}, 32'd1);

`ifdef PIPE_STALL_CNT_EN
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        chk("sc_after_rst", {16'd0, sc3}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (5) tick();
        chk("sc_five", {16'd0, sc3}, 32'd5);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("sc_after_flush", {16'd0, sc3}, 32'd5);
        drive(1'b1, 1'b0, 1'b1, 32'h2);
        tick();
        chk("sc_no_inc_en", {16'd0, sc3}, 32'd5);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (65535) tick();
        chk("sc_saturate", {16'd0, sc3}, 32'h0000_FFFF);
        tick();
        chk("sc_saturate_hold", {16'd0, sc3}, 32'h0000_FFFF);
        #2 reset_n = 1'b0;
        #1;
        chk("sc_async_rst", {16'd0, sc3}, 32'd0);
        reset_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
